fifo_pkt_framer: RTL and testbench

//  Drain stage behind the 8-bit sync FIFO. Reads buffered bytes and wraps them in framed packets: SOF, LEN, payload, CSUM.

---
 rtl/fifo_pkt_pkg.sv | 20 ++
 rtl/fifo_pkt_framer.sv | 173 +++++++++++++++++
 tb/tb_fifo_pkt_framer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkt_pkg.sv
// Shared definitions for the FIFO packet framer: frame marker, FSM states
// and the checksum finalisation helper.
package fifo_pkt_pkg;

  localparam logic [7:0] SOF_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    SOF,
    LEN,
    PAY,
    CSUM
  } state_t;

  // Two's-complement negation so that LEN + payload + CSUM sums to zero mod 256.
  function automatic logic [7:0] csum_final(input logic [7:0] sum);
    return (~sum) + 8'd1;
  endfunction

endpackage

// File: rtl/fifo_pkt_framer.sv
// Drains the upstream byte FIFO and wraps the bytes in SOF/LEN/payload/CSUM
// frames on a valid/ready byte stream. A frame starts on a full payload's
// worth of data or after a timeout with a partial, non-empty FIFO.
module fifo_pkt_framer
  import fifo_pkt_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int MAX_PAYLOAD = 8,
  parameter int TIMEOUT_CYC = 64,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [CNT_W-1:0]      fifo_count,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic [15:0]           frame_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0]      TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]      MAX_CNT  = CNT_W'(MAX_PAYLOAD);
  localparam logic [DATA_WIDTH-1:0] MAX_LEN  = DATA_WIDTH'(MAX_PAYLOAD);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [TMR_W-1:0]        r_tmr;
  logic [DATA_WIDTH-1:0]   r_len;
  logic [DATA_WIDTH-1:0]   r_req;
  logic [DATA_WIDTH-1:0]   r_ack;
  logic [DATA_WIDTH-1:0]   r_csum;
  logic                    r_pending;
  logic                    r_m_valid;
  logic [DATA_WIDTH-1:0]   r_m_data;
  logic                    r_m_last;
  logic [15:0]             r_frame_cnt;

  logic                    w_accept;
  logic                    w_out_free;
  logic                    w_full_start;
  logic                    w_tmo_start;
  logic                    w_start;
  logic                    w_rd_en;
  logic                    w_last_pay;
  logic [DATA_WIDTH-1:0]   w_len_latch;

  assign w_accept     = r_m_valid && m_ready;
  assign w_out_free   = !r_m_valid || m_ready;
  assign w_full_start = (fifo_count >= MAX_CNT);
  assign w_tmo_start  = !fifo_empty && (r_tmr == TMR_LAST);
  // When not full, occupancy is below MAX_PAYLOAD (<=255), so the cast is lossless.
  assign w_len_latch  = w_full_start ? MAX_LEN : DATA_WIDTH'(fifo_count);
  // Acceptance of the final payload byte of the frame.
  assign w_last_pay   = (r_state == PAY) && w_accept && (r_ack == (r_len - 1'b1));

  // Next-state and read-strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_rd_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_full_start || w_tmo_start) begin
          w_start     = 1'b1;
          w_state_nxt = SOF;
        end
      end
      SOF: begin
        if (w_accept) w_state_nxt = LEN;
      end
      LEN: begin
        if (w_accept) w_state_nxt = PAY;
      end
      PAY: begin
        w_rd_en = (r_req < r_len) && !r_pending && !fifo_empty && w_out_free;
        if (w_last_pay) w_state_nxt = CSUM;
      end
      CSUM: begin
        if (w_accept) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Partial-data timer: runs only in IDLE while the FIFO holds a short payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr <= '0;
    end else if ((r_state != IDLE) || fifo_empty || w_start) begin
      r_tmr <= '0;
    end else if (fifo_count < MAX_CNT) begin
      r_tmr <= r_tmr + 1'b1;
    end
  end

  // Frame bookkeeping: length, read/accept counters, outstanding read, checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len     <= '0;
      r_req     <= '0;
      r_ack     <= '0;
      r_csum    <= '0;
      r_pending <= 1'b0;
    end else if (w_start) begin
      r_len     <= w_len_latch;
      r_csum    <= w_len_latch;
      r_req     <= '0;
      r_ack     <= '0;
      r_pending <= 1'b0;
    end else begin
      // At most one read in flight; its data lands in the output reg next cycle.
      r_pending <= w_rd_en;
      if (w_rd_en)   r_req  <= r_req + 1'b1;
      if (r_pending) r_csum <= r_csum + fifo_rd_data;
      if ((r_state == PAY) && w_accept) r_ack <= r_ack + 1'b1;
    end
  end

  // Output register: holds its byte until accepted, then reloads or empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
    end else if (w_start) begin
      r_m_valid <= 1'b1;
      r_m_data  <= SOF_BYTE;
      r_m_last  <= 1'b0;
    end else if ((r_state == SOF) && w_accept) begin
      r_m_valid <= 1'b1;
      r_m_data  <= r_len;
      r_m_last  <= 1'b0;
    end else if ((r_state == PAY) && r_pending) begin
      r_m_valid <= 1'b1;
      r_m_data  <= fifo_rd_data;
      r_m_last  <= 1'b0;
    end else if (w_last_pay) begin
      r_m_valid <= 1'b1;
      r_m_data  <= csum_final(r_csum);
      r_m_last  <= 1'b1;
    end else if (w_accept) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end
  end

  // Completed-frame counter, bumped when the CSUM byte is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_frame_cnt <= '0;
    else if ((r_state == CSUM) && w_accept) r_frame_cnt <= r_frame_cnt + 1'b1;
  end

  assign fifo_rd_en = w_rd_en;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_last     = r_m_last;
  assign busy       = (r_state != IDLE);
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_fifo_pkt_framer.sv
// Directed bench for fifo_pkt_framer with a behavioural 16-deep sync FIFO.
module tb_fifo_pkt_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty;
  logic [4:0]  fifo_count;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data;
  logic        m_last;
  logic        busy;
  logic [15:0] frame_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_pkt_framer #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (16),
    .MAX_PAYLOAD(8),
    .TIMEOUT_CYC(64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo_empty  (fifo_empty),
    .fifo_count  (fifo_count),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .busy        (busy),
    .frame_cnt   (frame_cnt)
  );

  // Upstream FIFO model (registered read data, shares the reset).
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] mem [16];
  logic [3:0] wp, rp;
  logic [4:0] cnt;
  logic       do_rd, do_wr;

  assign do_rd      = fifo_rd_en && (cnt != 5'd0);
  assign do_wr      = wr_en && (cnt != 5'd16);
  assign fifo_empty = (cnt == 5'd0);
  assign fifo_count = cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= 4'd0;
      rp <= 4'd0;
      cnt <= 5'd0;
      fifo_rd_data <= 8'h00;
    end else begin
      if (do_wr) begin
        mem[wp] <= wr_data;
        wp <= wp + 4'd1;
      end
      if (do_rd) begin
        fifo_rd_data <= mem[rp];
        rp <= rp + 4'd1;
      end
      cnt <= cnt + {4'd0, do_wr} - {4'd0, do_rd};
    end
  end

  // Stream monitor, sampling 1 time unit before each rising edge.
  logic [7:0] cap_d [256];
  logic       cap_l [256];
  int         cap_n = 0;
  int         stab_err = 0;
  int         rd_err = 0;
  logic       hold_prev = 1'b0;
  logic [7:0] d_prev = 8'h00;
  logic       l_prev = 1'b0;

  always begin
    @(negedge clk);
    #4;
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && (m_valid !== 1'b1 || m_data !== d_prev || m_last !== l_prev))
        stab_err++;
      if (fifo_rd_en && fifo_empty) rd_err++;
      if (m_valid && m_ready) begin
        cap_d[cap_n] = m_data;
        cap_l[cap_n] = m_last;
        cap_n++;
      end
      hold_prev = m_valid && !m_ready;
      d_prev    = m_data;
      l_prev    = m_last;
    end
  end

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_frames(input logic [15:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (frame_cnt === target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    m_ready = 1'b0;
    wr_en   = 1'b0;
    repeat (3) @(negedge clk);
    n_assert++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b expected 0", m_valid); end
    n_assert++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL rst_m_data: got %02h expected 00", m_data); end
    n_assert++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL rst_m_last: got %b expected 0", m_last); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_assert++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_frame_cnt: got %0d expected 0", frame_cnt); end
    n_assert++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en: got %b expected 0", fifo_rd_en); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_flush_full();
    logic [8:0] exp [10];
    int base;
    bit ok;
    exp[0] = 9'h0A5;
    exp[1] = 9'h008;
    for (int i = 0; i < 8; i++) exp[2+i] = 9'(i + 1);
    m_ready = 1'b1;
    base = cap_n;
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_frames(16'd1, 200, ok);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL t1_done: frame_cnt %0d expected 1", frame_cnt); end
    n_assert++; if (cap_n - base != 11) begin n_fail++; $display("FAIL t1_len: got %0d bytes expected 11", cap_n - base); end
    for (int i = 0; i < 10; i++) begin
      n_assert++;
      if ({cap_l[base+i], cap_d[base+i]} !== exp[i]) begin
        n_fail++; $display("FAIL t1_byte%0d: got last=%b %02h expected last=0 %02h", i, cap_l[base+i], cap_d[base+i], exp[i][7:0]);
      end
    end
    n_assert++;
    if ({cap_l[base+10], cap_d[base+10]} !== 9'h1D4) begin
      n_fail++; $display("FAIL t1_csum: got last=%b %02h expected last=1 d4", cap_l[base+10], cap_d[base+10]);
    end
  endtask

  task automatic test_timeout();
    logic [8:0] exp [6];
    int base;
    int wait_cyc;
    bit ok;
    exp[0] = 9'h0A5; exp[1] = 9'h003; exp[2] = 9'h010;
    exp[3] = 9'h020; exp[4] = 9'h030; exp[5] = 9'h19D;
    m_ready = 1'b1;
    base = cap_n;
    push(8'h10); push(8'h20); push(8'h30);
    wait_cyc = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      wait_cyc = i;
      if (m_valid) break;
    end
    n_assert++; if (wait_cyc != 62) begin n_fail++; $display("FAIL t2_sof_delay: got %0d cycles expected 62", wait_cyc); end
    wait_frames(16'd2, 100, ok);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL t2_done: frame_cnt %0d expected 2", frame_cnt); end
    n_assert++; if (cap_n - base != 6) begin n_fail++; $display("FAIL t2_len: got %0d bytes expected 6", cap_n - base); end
    for (int i = 0; i < 6; i++) begin
      n_assert++;
      if ({cap_l[base+i], cap_d[base+i]} !== exp[i]) begin
        n_fail++; $display("FAIL t2_byte%0d: got %03h expected %03h", i, {cap_l[base+i], cap_d[base+i]}, exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] exp [11];
    int base;
    int stab_base;
    exp[0] = 9'h0A5;
    exp[1] = 9'h008;
    for (int i = 0; i < 8; i++) exp[2+i] = 9'(i + 1);
    exp[10] = 9'h1D4;
    m_ready = 1'b0;
    base = cap_n;
    stab_base = stab_err;
    for (int i = 1; i <= 8; i++) push(8'(i));
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (frame_cnt === 16'd3) break;
      m_ready = (cyc >= 12 && cyc < 17) ? 1'b0 : ((cyc % 2) == 0);
      @(negedge clk);
    end
    m_ready = 1'b1;
    n_assert++; if (frame_cnt !== 16'd3) begin n_fail++; $display("FAIL t3_done: frame_cnt %0d expected 3", frame_cnt); end
    n_assert++; if (cap_n - base != 11) begin n_fail++; $display("FAIL t3_len: got %0d bytes expected 11", cap_n - base); end
    for (int i = 0; i < 11; i++) begin
      n_assert++;
      if ({cap_l[base+i], cap_d[base+i]} !== exp[i]) begin
        n_fail++; $display("FAIL t3_byte%0d: got %03h expected %03h", i, {cap_l[base+i], cap_d[base+i]}, exp[i]);
      end
    end
    n_assert++; if (stab_err != stab_base) begin n_fail++; $display("FAIL t3_stable: got %0d unstable stalls expected 0", stab_err - stab_base); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp [22];
    int base;
    int rd_base;
    int idle;
    bit ok;
    exp[0] = 9'h0A5; exp[1] = 9'h008;
    for (int i = 0; i < 8; i++) exp[2+i] = 9'(8'h41 + i);
    exp[10] = 9'h1D4;
    exp[11] = 9'h0A5; exp[12] = 9'h008;
    for (int i = 0; i < 8; i++) exp[13+i] = 9'(8'h49 + i);
    exp[21] = 9'h194;
    m_ready = 1'b1;
    base = cap_n;
    rd_base = rd_err;
    for (int i = 0; i < 16; i++) push(8'(8'h41 + i));
    wait_frames(16'd4, 200, ok);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL t4_frame1: frame_cnt %0d expected 4", frame_cnt); end
    idle = 0;
    for (int i = 0; i < 50; i++) begin
      if (busy) break;
      idle++;
      @(negedge clk);
    end
    n_assert++; if (idle != 1) begin n_fail++; $display("FAIL t4_idle_gap: got %0d cycles expected 1", idle); end
    wait_frames(16'd5, 200, ok);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL t4_frame2: frame_cnt %0d expected 5", frame_cnt); end
    n_assert++; if (cap_n - base != 22) begin n_fail++; $display("FAIL t4_len: got %0d bytes expected 22", cap_n - base); end
    for (int i = 0; i < 22; i++) begin
      n_assert++;
      if ({cap_l[base+i], cap_d[base+i]} !== exp[i]) begin
        n_fail++; $display("FAIL t4_byte%0d: got %03h expected %03h", i, {cap_l[base+i], cap_d[base+i]}, exp[i]);
      end
    end
    n_assert++; if (rd_err != rd_base) begin n_fail++; $display("FAIL t4_rd_empty: got %0d reads while empty expected 0", rd_err - rd_base); end
  endtask

  task automatic test_reset_mid_frame();
    logic [8:0] exp [11];
    int base;
    bit ok;
    exp[0] = 9'h0A5;
    exp[1] = 9'h008;
    for (int i = 0; i < 8; i++) exp[2+i] = 9'(i + 1);
    exp[10] = 9'h1D4;
    m_ready = 1'b1;
    base = cap_n;
    for (int i = 0; i < 8; i++) push(8'(8'h61 + i));
    for (int i = 0; i < 200; i++) begin
      if (cap_n - base >= 5) break;
      @(negedge clk);
    end
    n_assert++; if (cap_n - base != 5) begin n_fail++; $display("FAIL t5_pre: got %0d bytes expected 5", cap_n - base); end
    rst_n = 1'b0;
    #1;
    n_assert++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL t5_m_valid: got %b expected 0", m_valid); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t5_busy: got %b expected 0", busy); end
    n_assert++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL t5_frame_cnt: got %0d expected 0", frame_cnt); end
    n_assert++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL t5_rd_en: got %b expected 0", fifo_rd_en); end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_assert++; if (cap_n - base != 5) begin n_fail++; $display("FAIL t5_no_csum: got %0d bytes expected 5", cap_n - base); end
    base = cap_n;
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_frames(16'd1, 200, ok);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL t5_done: frame_cnt %0d expected 1", frame_cnt); end
    for (int i = 0; i < 11; i++) begin
      n_assert++;
      if ({cap_l[base+i], cap_d[base+i]} !== exp[i]) begin
        n_fail++; $display("FAIL t5_byte%0d: got %03h expected %03h", i, {cap_l[base+i], cap_d[base+i]}, exp[i]);
      end
    end
  endtask

  task automatic test_empty_hold();
    int bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_assert++; if (bad != 0) begin n_fail++; $display("FAIL t6_quiet: got %0d active cycles expected 0", bad); end
    n_assert++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL t6_frame_cnt: got %0d expected 1", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_flush_full();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    test_empty_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
